// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide sequencer for the E stage, with a D-stage stall.
// Optional madd/maddu accumulate support is enabled by defining MD_MADD_EN.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned DW    = 2 * W;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } md_res_t;

  logic [CNT_W-1:0] cnt, cnt_n;
  md_res_t          res, res_n;
  logic             pend_we, pend_n;
  logic [W-1:0]     hi_n, lo_n;
  logic             busy_n;

  // Full-width products; signed variant uses sign-extended 64-bit operands.
  logic signed [DW-1:0] op_a_s, op_b_s, prod_s;
  logic [DW-1:0]        prod_u;

  assign op_a_s = {{W{rs_val[W-1]}}, rs_val};
  assign op_b_s = {{W{rt_val[W-1]}}, rt_val};
  assign prod_s = op_a_s * op_b_s;
  assign prod_u = {{W{1'b0}}, rs_val} * {{W{1'b0}}, rt_val};

  // Divide on magnitudes, then fix signs: quotient truncates, remainder follows dividend.
  logic         div_signed, rs_neg, rt_neg, div_zero;
  logic [W-1:0] dvd, dvs_mag, dvs, q_u, r_u, quo, rem;

  assign div_signed = (mdop == OP_DIV);
  assign rs_neg     = div_signed & rs_val[W-1];
  assign rt_neg     = div_signed & rt_val[W-1];
  assign div_zero   = (rt_val == '0);
  assign dvd        = rs_neg ? (W'(0) - rs_val) : rs_val;
  assign dvs_mag    = rt_neg ? (W'(0) - rt_val) : rt_val;
  assign dvs        = div_zero ? W'(1) : dvs_mag;
  assign q_u        = dvd / dvs;
  assign r_u        = dvd % dvs;
  assign quo        = (rs_neg ^ rt_neg) ? (W'(0) - q_u) : q_u;
  assign rem        = rs_neg ? (W'(0) - r_u) : r_u;

`ifdef MD_MADD_EN
  logic [DW-1:0] acc_s, acc_u;
  assign acc_s = {hi, lo} + DW'(prod_s);
  assign acc_u = {hi, lo} + prod_u;
`endif

  // Operations that occupy the unit and therefore must hold later HI/LO users.
  logic long_op;
`ifdef MD_MADD_EN
  assign long_op = (mdop <= OP_DIVU) | (mdop >= OP_MADD);
`else
  assign long_op = (mdop <= OP_DIVU);
`endif

  assign stall_md = d_md_use & (busy | (start & long_op));

  // Next-state: count down and commit, or accept a new operation when idle.
  always_comb begin
    cnt_n  = cnt;
    res_n  = res;
    pend_n = pend_we;
    hi_n   = hi;
    lo_n   = lo;
    if (cnt != '0) begin
      cnt_n = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        pend_n = 1'b0;
        if (pend_we) begin
          hi_n = res.hi;
          lo_n = res.lo;
        end
      end
    end else if (start) begin
      unique case (mdop)
        OP_MULT: begin
          res_n  = md_res_t'(prod_s);
          cnt_n  = MULT_LAT;
          pend_n = 1'b1;
        end
        OP_MULTU: begin
          res_n  = md_res_t'(prod_u);
          cnt_n  = MULT_LAT;
          pend_n = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          res_n  = '{hi: rem, lo: quo};
          cnt_n  = DIV_LAT;
          pend_n = ~div_zero;
        end
        OP_MTHI: hi_n = rs_val;
        OP_MTLO: lo_n = rs_val;
`ifdef MD_MADD_EN
        OP_MADD: begin
          res_n  = md_res_t'(acc_s);
          cnt_n  = MULT_LAT;
          pend_n = 1'b1;
        end
        OP_MADDU: begin
          res_n  = md_res_t'(acc_u);
          cnt_n  = MULT_LAT;
          pend_n = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    busy_n = (cnt_n != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      res     <= '0;
      pend_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      res     <= res_n;
      pend_we <= pend_n;
      hi      <= hi_n;
      lo      <= lo_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched (latency, results, stall, reset, madd).
module tb_md_sched;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk, reset, start, d_md_use;
  logic [2:0]  mdop;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } exp_t;

  exp_t sbq[$];

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Drive one start pulse; returns in the cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdop = op; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
  endtask

  // Count busy cycles from the current one until idle (bounded).
  task automatic wait_idle(output int unsigned n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; d_md_use = 1'b1; start = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=0", lo); end
    checks++; if (stall_md !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b want=0", stall_md); end
    start = 1'b1; mdop = 3'd0;
    #1;
    checks++; if (stall_md !== 1'b1) begin failures++; $display("FAIL reset_stall_start got=%b want=1", stall_md); end
    start = 1'b0; d_md_use = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int unsigned n;
    exp_t e;
    logic [31:0] a, b;
    logic [63:0] p;
    sbq.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, lat: MULT_N});
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_idle(n);
    e = sbq.pop_front();
    checks++; if (n !== e.lat) begin failures++; $display("FAIL mult_lat got=%0d want=%0d", n, e.lat); end
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL mult_hi got=%h want=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL mult_lo got=%h want=%h", lo, e.lo); end
    sbq.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, lat: MULT_N});
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    e = sbq.pop_front();
    checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL multu_max got=%h%h want=%h%h", hi, lo, e.hi, e.lo); end
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      sbq.push_back('{hi: p[63:32], lo: p[31:0], lat: MULT_N});
      issue(3'd1, a, b);
      wait_idle(n);
      e = sbq.pop_front();
      checks++;
      if (n !== e.lat || hi !== e.hi || lo !== e.lo) begin
        failures++;
        $display("FAIL multu_rand%0d got=%0d/%h%h want=%0d/%h%h", i, n, hi, lo, e.lat, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div();
    int unsigned n;
    exp_t e;
    logic [2:0]  ops [5] = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [31:0] av  [5] = '{32'd17, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bv  [5] = '{32'd5, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd10};
    logic [31:0] eh  [5] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5};
    logic [31:0] el  [5] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h19999999};
    for (int i = 0; i < 5; i++) begin
      sbq.push_back('{hi: eh[i], lo: el[i], lat: DIV_N});
      issue(ops[i], av[i], bv[i]);
      wait_idle(n);
      e = sbq.pop_front();
      checks++; if (n !== e.lat) begin failures++; $display("FAIL div%0d_lat got=%0d want=%0d", i, n, e.lat); end
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
        failures++;
        $display("FAIL div%0d_res got=hi %h lo %h want=hi %h lo %h", i, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_mt_divzero();
    int unsigned n;
    do_reset();
    issue(3'd4, 32'h1234, 32'd0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b want=0", busy); end
    checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi_hi got=%h want=1234", hi); end
    issue(3'd2, 32'd99, 32'd0);
    wait_idle(n);
    checks++; if (n !== DIV_N) begin failures++; $display("FAIL divzero_lat got=%0d want=%0d", n, DIV_N); end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'd0) begin
      failures++;
      $display("FAIL divzero_keep got=hi %h lo %h want=hi 1234 lo 0", hi, lo);
    end
    issue(3'd5, 32'hCAFE, 32'd0);
    checks++; if (lo !== 32'hCAFE || busy !== 1'b0) begin failures++; $display("FAIL mtlo got=lo %h busy %b want=lo cafe busy 0", lo, busy); end
  endtask

  task automatic test_stall();
    for (int pass = 0; pass < 2; pass++) begin
      d_md_use = (pass == 0);
      start = 1'b1; mdop = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
      #1;
      checks++; if (stall_md !== d_md_use) begin failures++; $display("FAIL stall_start%0d got=%b want=%b", pass, stall_md, d_md_use); end
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(MULT_N); i++) begin
        checks++;
        if (busy !== 1'b1 || stall_md !== d_md_use) begin
          failures++;
          $display("FAIL stall_busy%0d_c%0d got=busy %b stall %b want=busy 1 stall %b", pass, i, busy, stall_md, d_md_use);
        end
        tick();
      end
      checks++; if (busy !== 1'b0 || stall_md !== 1'b0) begin failures++; $display("FAIL stall_idle%0d got=busy %b stall %b want=0 0", pass, busy, stall_md); end
    end
    d_md_use = 1'b1; start = 1'b1; mdop = 3'd4;
    #1;
    checks++; if (stall_md !== 1'b0) begin failures++; $display("FAIL stall_mthi got=%b want=0", stall_md); end
    start = 1'b0; d_md_use = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 32'hAAAA, 32'd0);
    issue(3'd5, 32'h5555, 32'd0);
    issue(3'd0, 32'd7, 32'd9);
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid got=busy %b hi %h lo %h want=0 0 0", busy, hi, lo);
    end
    #3 reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_nocommit got=busy %b hi %h lo %h want=0 0 0", busy, hi, lo);
    end
  endtask

  // A start held through the whole divide, including the commit cycle, must wait until idle.
  task automatic test_back_to_back();
    int unsigned n;
    exp_t e;
    sbq.push_back('{hi: 32'd2, lo: 32'd3, lat: DIV_N});
    sbq.push_back('{hi: 32'd0, lo: 32'd9, lat: MULT_N});
    issue(3'd3, 32'd17, 32'd5);
    start = 1'b1; mdop = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
    wait_idle(n);
    e = sbq.pop_front();
    checks++; if (n !== e.lat) begin failures++; $display("FAIL b2b_first_lat got=%0d want=%0d", n, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL b2b_first got=hi %h lo %h want=hi %h lo %h", hi, lo, e.hi, e.lo); end
    tick();
    start = 1'b0;
    wait_idle(n);
    e = sbq.pop_front();
    checks++; if (n !== e.lat) begin failures++; $display("FAIL b2b_second_lat got=%0d want=%0d", n, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL b2b_second got=hi %h lo %h want=hi %h lo %h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_madd();
    int unsigned n;
    exp_t e;
    do_reset();
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
`ifdef MD_MADD_EN
    sbq.push_back('{hi: 32'd1, lo: 32'd5, lat: MULT_N});
    issue(3'd6, 32'd2, 32'd3);
    wait_idle(n);
    e = sbq.pop_front();
    checks++; if (n !== e.lat) begin failures++; $display("FAIL madd_lat got=%0d want=%0d", n, e.lat); end
    checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL madd got=hi %h lo %h want=hi %h lo %h", hi, lo, e.hi, e.lo); end
`else
    issue(3'd6, 32'd2, 32'd3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL madd_off_busy got=%b want=0", busy); end
    for (int i = 0; i < int'(MULT_N) + 1; i++) tick();
    e = '{hi: 32'd0, lo: 32'hFFFFFFFF, lat: 0};
    checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL madd_off got=hi %h lo %h want=hi %h lo %h", hi, lo, e.hi, e.lo); end
    n = 0;
`endif
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; d_md_use = 1'b0;
    mdop = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_madd();
    checks++; if (sbq.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_sched.md
# md_sched

Sequencing controller for the multiply/divide unit in the E stage of the pipelined MIPS CPU. It accepts a HI/LO-class operation from the E-stage decode, holds the HI/LO pair busy for a fixed multi-cycle latency, and commits the result to HI/LO when the latency expires. It also drives the D-stage stall that keeps later HI/LO users from issuing while the unit is busy.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd/maddu (legal range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal range 1..15).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  E-stage instruction is an MD operation this cycle.
- `mdop`  in  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- `rs_val`  in  32  forwarded rs operand.
- `rt_val`  in  32  forwarded rt operand.
- `d_md_use`  in  1  D-stage instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult*, div*, madd*).
- `busy`  out  1  multi-cycle operation in progress.
- `stall_md`  out  1  stall request to the hazard unit.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Registers: `hi`, `lo`, 4-bit down-counter `cnt`, 32-bit pending `res_hi` and `res_lo`, and a 1-bit `pend_we`.
- Idle is `cnt == 0`. `busy = (cnt != 0)`.
- `start` is accepted only when `busy == 0`. A `start` while busy is ignored; the hazard unit guarantees it does not occur.
- Accepted mult/multu (sign-extended or zero-extended 64-bit product) or div/divu (LO = quotient, HI = remainder; remainder takes the sign of the dividend, quotient truncates toward zero):
  - result computed at acceptance into `res_hi`/`res_lo`;
  - `cnt` loaded with `MULT_CYCLES` or `DIV_CYCLES`;
  - `pend_we` set to 1.
- Divide by zero (`rt_val == 0`) still occupies `DIV_CYCLES`. `pend_we` is set to 0, so HI/LO retain their old values.
- Accepted mthi/mtlo: `hi`/`lo` written with `rs_val` at that edge. `cnt` is not loaded and `busy` stays 0.
- Each cycle with `cnt != 0`, `cnt` decrements. On the edge where `cnt == 1`, `hi`/`lo` take `res_hi`/`res_lo` if `pend_we` is set.
- `stall_md = d_md_use & (busy | (start & mdop <= 3 or mdop >= 6))`. This is combinational.
- `hi`/`lo` outputs are the registers themselves (mfhi/mflo read them directly).
- Arithmetic: all 32x32 operations produce a full 64-bit result, with no truncation. Signed overflow of the quotient (0x80000000 / -1) gives LO = 0x80000000 and HI = 0.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - `hi = lo = 0`, `cnt = 0`, `busy = 0`, `pend_we = 0`, `res_hi = res_lo = 0`;
  - `stall_md` follows its inputs with `busy = 0`;
  - a pending result is discarded.
- `start` sampled at the end of cycle T: `busy` is high in cycles T+1 .. T+N (N = the latency parameter). HI/LO are updated at the end of cycle T+N and readable in cycle T+N+1, when `busy` is 0.
- A new `start` is accepted in cycle T+N+1 at the earliest. Back-to-back operations therefore have an N+1 cycle issue interval.
- mthi/mtlo at cycle T: the new value is visible in cycle T+1 with zero busy cycles.
- If a commit (`cnt == 1`) and a `start` coincide, the start is ignored, because `busy = 1` in that cycle.

## Configuration
- `MD_MADD_EN`:
  - Defined: mdop 6/7 perform signed/unsigned `{hi,lo} += rs_val*rt_val` (64-bit wrap-around). The accumulate uses the `hi`/`lo` values at acceptance, with latency `MULT_CYCLES`.
  - Undefined: mdop 6/7 are treated as no-ops. Nothing is accepted, `busy` stays 0, HI/LO are unchanged, and they are excluded from the `start` term of `stall_md`.

## Test plan
- Reset, then mult `rs=0xFFFFFFFD`, `rt=5` -> `busy` high for exactly 5 cycles; then `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`.
- divu `17/5`, then div `0xFFFFFFF9/2` -> first gives `lo=3`, `hi=2`; second gives `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`; each with 10 busy cycles.
- mthi `0x1234`, then div with `rt=0` -> `hi=0x1234` visible next cycle, with no busy; the divide is busy for 10 cycles and `hi` stays `0x1234`, `lo` stays 0.
- mult in flight with `d_md_use=1` -> `stall_md=1` in the start cycle and every busy cycle, and 0 in the first idle cycle; with `d_md_use=0`, `stall_md=0` throughout.
- Assert `reset` low at busy cycle 3 of a mult -> `busy`, `hi` and `lo` are 0 immediately, and no commit occurs afterward.
- `MD_MADD_EN` defined: `hi=0`, `lo=0xFFFFFFFF`, madd `2*3` -> `hi=1`, `lo=5`. Undefined: the same stimulus leaves `busy=0` and `hi`/`lo` unchanged.
